// File: rtl/cover_pkg.sv
// Shared helpers for toggle-coverage blocks: cover point encoding, default index width, popcount.
package cover_pkg;

    localparam int IDX_W_DEF = 32;
    localparam int POP_MAX   = 1024;

    function automatic int pt_rise(input int i);
        return 2 * i;
    endfunction

    function automatic int pt_fall(input int i);
        return 2 * i + 1;
    endfunction

    // Callers zero-extend their vector to POP_MAX bits before calling.
    function automatic int popcount(input logic [POP_MAX-1:0] v);
        int n;
        n = 0;
        for (int k = 0; k < POP_MAX; k++)
            if (v[k]) n++;
        return n;
    endfunction

endpackage

// File: rtl/cover_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or above ptr, else first set bit overall.
module cover_rr_pick #(
    parameter int N  = 88,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          gnt_valid,
    output logic [PW-1:0] gnt_idx
);

    logic          hi_found, lo_found;
    logic [PW-1:0] hi_idx, lo_idx;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!hi_found && req[k] && (PW'(k) >= ptr)) begin
                hi_found = 1'b1;
                hi_idx   = PW'(k);
            end
            if (!lo_found && req[k]) begin
                lo_found = 1'b1;
                lo_idx   = PW'(k);
            end
        end
    end

    // Upper half wins; the lower search only matters once the search wraps past N-1.
    assign gnt_valid = hi_found | lo_found;
    assign gnt_idx   = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/cover_toggle_reporter.sv
// Toggle coverage monitor: detects per-bit rise/fall, records first hits sticky,
// and drains newly covered points one per cycle over a valid/ready channel.
module cover_toggle_reporter
    import cover_pkg::*;
#(
    parameter int WIDTH       = 44,
    parameter int COVER_INDEX = 0,
    parameter int IDX_W       = IDX_W_DEF,
    localparam int NPTS       = 2 * WIDTH,
    localparam int PW         = $clog2(NPTS),
    localparam int CW         = $clog2(NPTS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample,
    input  logic             clear,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [IDX_W-1:0] rpt_index,
    output logic [CW-1:0]    hit_count,
    output logic             busy
);

    logic [WIDTH-1:0] prev;
    logic             primed;
    logic [NPTS-1:0]  covered, pending;
    logic [PW-1:0]    ptr;

    logic [NPTS-1:0]  events, new_hits, pick_oh;
    logic             gnt_valid, load;
    logic [PW-1:0]    gnt_idx;

    always_comb begin
        events = '0;
        for (int i = 0; i < WIDTH; i++) begin
            events[pt_rise(i)] = ~prev[i] &  sample[i];
            events[pt_fall(i)] =  prev[i] & ~sample[i];
        end
        if (!(enable && primed && !clear)) events = '0;
    end

    assign new_hits = events & ~covered;

    cover_rr_pick #(.N(NPTS), .PW(PW)) u_pick (
        .req      (pending),
        .ptr      (ptr),
        .gnt_valid(gnt_valid),
        .gnt_idx  (gnt_idx)
    );

    assign load = gnt_valid && (!rpt_valid || rpt_ready);

    always_comb begin
        pick_oh = '0;
        pick_oh[gnt_idx] = load;
    end

    assign busy = rpt_valid | (|pending);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev      <= '0;
            primed    <= 1'b0;
            covered   <= '0;
            pending   <= '0;
            ptr       <= '0;
            rpt_valid <= 1'b0;
            rpt_index <= '0;
            hit_count <= '0;
        end else if (clear) begin
            // Drops any in-flight beat; handshakes and events this cycle are discarded.
            primed    <= 1'b0;
            covered   <= '0;
            pending   <= '0;
            ptr       <= '0;
            rpt_valid <= 1'b0;
            hit_count <= '0;
        end else begin
            if (enable) begin
                prev   <= sample;
                primed <= 1'b1;
            end
            covered   <= covered | new_hits;
            pending   <= (pending | new_hits) & ~pick_oh;
            hit_count <= hit_count + CW'(popcount(POP_MAX'(new_hits)));
            if (load) begin
                rpt_valid <= 1'b1;
                rpt_index <= IDX_W'(COVER_INDEX) + IDX_W'(gnt_idx);
                ptr       <= (gnt_idx == PW'(NPTS - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (rpt_valid && rpt_ready) begin
                rpt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cover_toggle_reporter.sv
// Directed bench for cover_toggle_reporter: priming, latency, stall/drain, wrap, clear, enable gating, async reset.
module tb_cover_toggle_reporter;

    localparam int WIDTH = 44;
    localparam int CI    = 1000;
    localparam int IDX_W = 32;
    localparam int CW    = $clog2(2 * WIDTH + 1);

    logic             clock = 1'b0;
    logic             reset, enable, clear, rpt_ready;
    logic [WIDTH-1:0] sample;
    logic             rpt_valid, busy;
    logic [IDX_W-1:0] rpt_index;
    logic [CW-1:0]    hit_count;

    int n_chk  = 0;
    int n_pass = 0;
    logic [WIDTH-1:0] s, held;
    logic [IDX_W-1:0] q[$];

    cover_toggle_reporter #(.WIDTH(WIDTH), .COVER_INDEX(CI), .IDX_W(IDX_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .sample   (sample),
        .clear    (clear),
        .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready),
        .rpt_index(rpt_index),
        .hit_count(hit_count),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    // Beats that will be accepted at the coming rising edge.
    always @(negedge clock)
        if (rpt_valid && rpt_ready && !clear && !reset) q.push_back(rpt_index);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] v);
        s      = v;
        sample = v;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; rpt_ready = 1'b1; drive('0);
        #3;
        chk("rst_valid", rpt_valid, 0);
        chk("rst_index", rpt_index, 0);
        chk("rst_hits",  hit_count, 0);
        chk("rst_busy",  busy, 0);
        tick(); tick();
        reset = 1'b0;

        // 1: prime on 0, toggle to 1, beat two cycles later
        enable = 1'b1; drive('0);
        tick();
        chk("t1_prime_busy", busy, 0);
        drive(44'h1);
        tick();
        chk("t1_pend_busy", busy, 1);
        chk("t1_pend_valid", rpt_valid, 0);
        chk("t1_hits", hit_count, 1);
        tick();
        chk("t1_valid", rpt_valid, 1);
        chk("t1_index", rpt_index, CI + 0);
        tick();
        chk("t1_drop_valid", rpt_valid, 0);
        chk("t1_idle_busy", busy, 0);

        // 2: repeated toggles report each point once
        drive(44'h0); tick();
        drive(44'h1); tick();
        drive(44'h0); tick();
        tick(); tick();
        chk("t2_hits", hit_count, 2);
        chk("t2_nbeats", q.size(), 2);
        chk("t2_beat0", (q.size() > 0) ? q[0] : '1, CI + 0);
        chk("t2_beat1", (q.size() > 1) ? q[1] : '1, CI + 1);
        chk("t2_busy", busy, 0);

        // 3: fresh epoch, all rises with collector stalled, then full-rate drain
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t3_clr_hits", hit_count, 0);
        drive('0); tick();
        rpt_ready = 1'b0;
        drive('1); tick();
        chk("t3_hits", hit_count, 44);
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("t3_stall_valid", rpt_valid, 1);
            chk("t3_stall_index", rpt_index, CI + 0);
            tick();
        end
        rpt_ready = 1'b1;
        for (int k = 0; k < 44; k++) begin
            chk("t3_drain_valid", rpt_valid, 1);
            chk("t3_drain_index", rpt_index, CI + 2 * k);
            tick();
        end
        chk("t3_end_valid", rpt_valid, 0);
        chk("t3_end_busy", busy, 0);

        // 4: ptr sits past 86; falls on bits 0 and 43 give points 1 and 87 -> 87 first
        drive(s & ~44'h800_0000_0001); tick();
        chk("t4_hits", hit_count, 46);
        tick();
        chk("t4_first", rpt_index, CI + 87);
        tick();
        chk("t4_second", rpt_index, CI + 1);
        chk("t4_second_v", rpt_valid, 1);
        tick();
        chk("t4_end_valid", rpt_valid, 0);

        // 5: clear while a beat is held and more is pending, with a same-cycle toggle
        rpt_ready = 1'b0;
        drive(s & ~44'h6); tick();
        chk("t5_hits", hit_count, 48);
        tick();
        chk("t5_held_valid", rpt_valid, 1);
        chk("t5_held_index", rpt_index, CI + 3);
        clear = 1'b1; drive(s & ~44'h8); tick(); clear = 1'b0;
        chk("t5_clr_valid", rpt_valid, 0);
        chk("t5_clr_hits", hit_count, 0);
        chk("t5_clr_busy", busy, 0);
        drive(s ^ 44'h10); tick();
        tick(); tick();
        chk("t5_prime_hits", hit_count, 0);
        chk("t5_prime_busy", busy, 0);
        rpt_ready = 1'b1;
        drive(s | 44'h1); tick();
        chk("t5_rehit", hit_count, 1);
        tick();
        chk("t5_rep_valid", rpt_valid, 1);
        chk("t5_rep_index", rpt_index, CI + 0);
        tick();

        // 6: enable low freezes history; re-enable at the held value sees no toggle
        held = s;
        enable = 1'b0;
        drive(44'h0); tick();
        drive(44'h3); tick();
        drive(44'h0); tick();
        chk("t6_frozen_hits", hit_count, 1);
        chk("t6_frozen_busy", busy, 0);
        enable = 1'b1; drive(held); tick(); tick();
        chk("t6_held_hits", hit_count, 1);
        chk("t6_held_busy", busy, 0);

        // async reset while a beat is stalled
        rpt_ready = 1'b0;
        drive(s ^ 44'h20); tick(); tick();
        chk("t6_beat_valid", rpt_valid, 1);
        chk("t6_beat_index", rpt_index, CI + 11);
        #2 reset = 1'b1;
        #1;
        chk("t6_arst_valid", rpt_valid, 0);
        chk("t6_arst_index", rpt_index, 0);
        chk("t6_arst_hits", hit_count, 0);
        chk("t6_arst_busy", busy, 0);
        tick();
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
